// File: rtl/fetch_unit.sv
// Fetch PC register and single-outstanding instruction fetch stage with a one-entry decode buffer.
// Optional FETCH_MISALIGN_TRAP_EN adds if_misaligned and traps misaligned fetch PCs instead of fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] new_pc,
    output logic [31:0] current_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        if_misaligned,
`endif
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] current_pc_q, current_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        buf_free;
    logic        issue;
    logic        consume;
    logic        pc_misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        if_misaligned_q, if_misaligned_d;
    assign pc_misaligned = (current_pc_q[1:0] != 2'b00);
    assign imem_addr     = current_pc_q;
    assign if_misaligned = if_misaligned_q;
`else
    assign pc_misaligned = 1'b0;
    assign imem_addr     = {current_pc_q[31:2], 2'b00};
`endif

    // A fill may only land in an empty or draining buffer.
    assign buf_free = !if_valid_q || id_ready;
    assign imem_req = !rst && (state_q == S_REQ) && !redirect
                      && buf_free && !pc_misaligned;
    assign issue    = imem_req && imem_ready;
    assign consume  = if_valid_q && id_ready;

    assign current_pc = current_pc_q;
    assign if_valid   = if_valid_q;
    assign if_inst    = if_inst_q;
    assign if_pc      = if_pc_q;

    always_comb begin
        state_d      = state_q;
        current_pc_d = current_pc_q;
        req_pc_d     = req_pc_q;
        if_valid_d   = if_valid_q;
        if_inst_d    = if_inst_q;
        if_pc_d      = if_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        if_misaligned_d = if_misaligned_q;
`endif
        if (consume) begin
            if_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if_misaligned_d = 1'b0;
`endif
        end
        unique case (state_q)
            S_REQ: begin
                if (issue) begin
                    req_pc_d     = current_pc_q;
                    current_pc_d = new_pc;
                    state_d      = S_WAIT;
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                else if (!redirect && buf_free && pc_misaligned) begin
                    if_valid_d      = 1'b1;
                    if_misaligned_d = 1'b1;
                    if_pc_d         = current_pc_q;
                    if_inst_d       = NOP_INST;
                end
`endif
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                    if (!redirect) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = imem_rdata;
                        if_pc_d    = req_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if_misaligned_d = 1'b0;
`endif
                    end
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        // Redirect flushes the buffer and overrides everything else.
        if (redirect) begin
            current_pc_d = new_pc;
            if_valid_d   = 1'b0;
            if_inst_d    = NOP_INST;
`ifdef FETCH_MISALIGN_TRAP_EN
            if_misaligned_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            current_pc_q <= RESET_PC;
            req_pc_q     <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_inst_q    <= NOP_INST;
            if_pc_q      <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if_misaligned_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            current_pc_q <= current_pc_d;
            req_pc_q     <= req_pc_d;
            if_valid_q   <= if_valid_d;
            if_inst_q    <= if_inst_d;
            if_pc_q      <= if_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            if_misaligned_q <= if_misaligned_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic against
// an in-order fetch-stream model and a single-outstanding memory model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h100;
    localparam logic [31:0] NOP    = 32'h13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic [31:0] current_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        if_misaligned;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(RST_PC),
        .NOP_INST(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .new_pc     (new_pc),
        .current_pc (current_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .if_misaligned(if_misaligned),
`endif
        .id_ready   (id_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // memory model: one outstanding request, fixed latency per request
    bit          pending = 0;
    bit          stale   = 0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;
    bit          use_override = 0;
    logic [31:0] override_data = 32'h0;

    // fetch-stream model: next address to be requested, next PC to be consumed
    logic [31:0] exp_addr = RST_PC;
    logic [31:0] exp_pc   = RST_PC;
    logic [31:0] cons_pc[$];
    int          cons_cyc[$];

    bit          req_s;
    logic [31:0] addr_s;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[17:2] ^ 16'h5A3C, ~a[17:2]};
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] a);
`ifdef FETCH_MISALIGN_TRAP_EN
        return a;
`else
        return {a[31:2], 2'b00};
`endif
    endfunction

    task automatic step(input bit r, input bit redir, input logic [31:0] tgt,
                        input bit rdy, input bit mready, input int lat);
        bit issue;
        bit consume;
        @(negedge clk);
        rst         = r;
        redirect    = redir;
        id_ready    = rdy;
        imem_ready  = mready && !pending;
        imem_rvalid = pending && (pend_cnt == 0);
        if (imem_rvalid)
            imem_rdata = use_override ? override_data : mem_word(pend_addr);
        else
            imem_rdata = $urandom;
        new_pc = redir ? tgt : current_pc + 32'd4;
        #1;
        req_s   = imem_req;
        addr_s  = imem_addr;
        issue   = imem_req && imem_ready;
        consume = !r && if_valid && rdy;
        if (pending && !stale) begin
            n_checks++;
            if (imem_req !== 1'b0)
                $display("FAIL one_outstanding: imem_req=%b want 0", imem_req);
            else
                n_pass++;
        end
        if (issue) begin
            n_checks++;
            if (imem_addr !== word_addr(exp_addr))
                $display("FAIL issue_addr: got %h want %h", imem_addr, word_addr(exp_addr));
            else
                n_pass++;
        end
        if (consume) begin
            n_checks++;
            if (if_pc !== exp_pc)
                $display("FAIL if_pc: got %h want %h", if_pc, exp_pc);
            else
                n_pass++;
            n_checks++;
            if (if_inst !== mem_word(exp_pc))
                $display("FAIL if_inst: got %h want %h", if_inst, mem_word(exp_pc));
            else
                n_pass++;
            cons_pc.push_back(if_pc);
            cons_cyc.push_back(cyc);
            exp_pc = exp_pc + 32'd4;
        end
        if (imem_rvalid) begin
            pending = 0;
            stale   = 0;
        end else if (pending) begin
            pend_cnt--;
        end
        if (issue) begin
            pending   = 1;
            pend_addr = imem_addr;
            pend_cnt  = lat - 1;
            exp_addr  = exp_addr + 32'd4;
        end
        if (r) begin
            exp_addr = RST_PC;
            exp_pc   = RST_PC;
            if (pending) stale = 1;
        end else if (redir) begin
            exp_addr = tgt;
            exp_pc   = tgt;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (redir && !r) begin
            n_checks++;
            if (current_pc !== tgt || if_valid !== 1'b0 || if_inst !== NOP)
                $display("FAIL redirect_flush: pc=%h v=%b inst=%h want pc=%h v=0 inst=%h",
                         current_pc, if_valid, if_inst, tgt, NOP);
            else
                n_pass++;
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 20 && (pending || if_valid); i++)
            step(0, 0, 32'h0, 1, 0, 1);
        n_checks++;
        if (pending || if_valid)
            $display("FAIL settle: pending=%b if_valid=%b want 0/0", pending, if_valid);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 32'h0, 0, 1, 1);
            n_checks++;
            if (req_s !== 1'b0)
                $display("FAIL reset_req: got %b want 0", req_s);
            else
                n_pass++;
        end
        n_checks++;
        if (current_pc !== RST_PC || if_valid !== 1'b0 || if_inst !== NOP || if_pc !== 32'h0)
            $display("FAIL reset_state: pc=%h v=%b inst=%h ifpc=%h want %h 0 %h 0",
                     current_pc, if_valid, if_inst, if_pc, RST_PC, NOP);
        else
            n_pass++;
        step(0, 0, 32'h0, 1, 0, 1);
        n_checks++;
        if (req_s !== 1'b1 || addr_s !== RST_PC)
            $display("FAIL reset_release: req=%b addr=%h want 1 %h", req_s, addr_s, RST_PC);
        else
            n_pass++;
    endtask

    task automatic test_sequential();
        int vcnt;
        vcnt = 0;
        cons_pc.delete();
        cons_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 32'h0, 1, 1, 1);
            vcnt += int'(if_valid);
        end
        n_checks++;
        if (cons_pc.size() != 4)
            $display("FAIL seq_count: got %0d want 4", cons_pc.size());
        else
            n_pass++;
        n_checks++;
        if (vcnt != 5)
            $display("FAIL seq_valid_cycles: got %0d want 5", vcnt);
        else
            n_pass++;
        for (int i = 0; i < 4 && i < cons_pc.size(); i++) begin
            n_checks++;
            if (cons_pc[i] !== RST_PC + 32'(4 * i))
                $display("FAIL seq_pc%0d: got %h want %h", i, cons_pc[i], RST_PC + 32'(4 * i));
            else
                n_pass++;
            if (i > 0) begin
                n_checks++;
                if (cons_cyc[i] - cons_cyc[i-1] != 2)
                    $display("FAIL seq_spacing%0d: got %0d want 2", i, cons_cyc[i] - cons_cyc[i-1]);
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] p0;
        logic [31:0] i0;
        p0 = if_pc;
        i0 = if_inst;
        n_checks++;
        if (if_valid !== 1'b1 || p0 !== 32'h110)
            $display("FAIL stall_pre: v=%b pc=%h want 1 00000110", if_valid, p0);
        else
            n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0, 0, 1, 1);
            n_checks++;
            if (req_s !== 1'b0 || if_pc !== p0 || if_inst !== i0 || if_valid !== 1'b1)
                $display("FAIL stall_hold: req=%b pc=%h inst=%h v=%b want 0 %h %h 1",
                         req_s, if_pc, if_inst, if_valid, p0, i0);
            else
                n_pass++;
        end
        step(0, 0, 32'h0, 1, 1, 1);
        n_checks++;
        if (req_s !== 1'b1 || if_valid !== 1'b0)
            $display("FAIL stall_release: req=%b v=%b want 1 0", req_s, if_valid);
        else
            n_pass++;
    endtask

    task automatic test_redirect_wait();
        settle();
        step(0, 0, 32'h0, 1, 1, 4);
        use_override  = 1;
        override_data = 32'hDEAD_BEEF;
        step(0, 1, 32'h200, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0, 0, 0, 1);
            n_checks++;
            if (if_valid !== 1'b0)
                $display("FAIL drop_valid: got %b want 0 (inst %h)", if_valid, if_inst);
            else
                n_pass++;
        end
        use_override = 0;
        step(0, 0, 32'h0, 1, 1, 1);
        n_checks++;
        if (req_s !== 1'b1 || addr_s !== 32'h200)
            $display("FAIL drop_next_addr: req=%b addr=%h want 1 00000200", req_s, addr_s);
        else
            n_pass++;
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 1, 1);
    endtask

    task automatic test_redirect_rvalid();
        settle();
        step(0, 0, 32'h0, 1, 1, 1);
        n_checks++;
        if (!pending || pend_cnt != 0)
            $display("FAIL rv_setup: pending=%b cnt=%0d want 1 0", pending, pend_cnt);
        else
            n_pass++;
        step(0, 1, 32'h300, 0, 1, 1);
        step(0, 0, 32'h0, 0, 1, 1);
        n_checks++;
        if (req_s !== 1'b1 || addr_s !== 32'h300)
            $display("FAIL rv_state_req: req=%b addr=%h want 1 00000300", req_s, addr_s);
        else
            n_pass++;
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 1, 1);
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    task automatic test_misalign();
        settle();
        step(0, 1, 32'h202, 0, 0, 1);
        step(0, 0, 32'h0, 0, 1, 1);
        n_checks++;
        if (req_s !== 1'b0)
            $display("FAIL mis_req: got %b want 0", req_s);
        else
            n_pass++;
        n_checks++;
        if (if_valid !== 1'b1 || if_misaligned !== 1'b1 || if_pc !== 32'h202 || if_inst !== NOP)
            $display("FAIL mis_trap: v=%b m=%b pc=%h inst=%h want 1 1 00000202 %h",
                     if_valid, if_misaligned, if_pc, if_inst, NOP);
        else
            n_pass++;
        step(0, 0, 32'h0, 0, 1, 1);
        n_checks++;
        if (current_pc !== 32'h202 || req_s !== 1'b0)
            $display("FAIL mis_hold: pc=%h req=%b want 00000202 0", current_pc, req_s);
        else
            n_pass++;
        step(0, 1, 32'h400, 0, 0, 1);
        n_checks++;
        if (if_misaligned !== 1'b0)
            $display("FAIL mis_clear: got %b want 0", if_misaligned);
        else
            n_pass++;
    endtask
`else
    task automatic test_misalign();
        settle();
        step(0, 1, 32'h206, 0, 0, 1);
        step(0, 0, 32'h0, 1, 1, 1);
        n_checks++;
        if (req_s !== 1'b1 || addr_s !== 32'h204)
            $display("FAIL align_addr: req=%b addr=%h want 1 00000204", req_s, addr_s);
        else
            n_pass++;
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, 1, 1);
        step(0, 1, 32'h400, 0, 0, 1);
    endtask
`endif

    task automatic test_random();
        int base;
        bit r;
        bit rd;
        base = cons_pc.size();
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 149) == 0);
            rd = !r && ($urandom_range(0, 15) == 0);
            step(r, rd, 32'($urandom_range(0, 16383)) << 2,
                 !rd && ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 3) != 0,
                 int'($urandom_range(1, 4)));
        end
        n_checks++;
        if (cons_pc.size() - base < 50)
            $display("FAIL rand_progress: consumed %0d want >=50", cons_pc.size() - base);
        else
            n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
